// File: rtl/div_iter.sv
// Iterative restoring divider for MIPS DIV/DIVU.
// The quotient goes to LO and the remainder to HI. One quotient bit is
// produced per clock; the pipeline stalls on busy and captures the
// results on the single-cycle done pulse.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   S_IDLE | waiting for start; results from the last operation held
//   S_CALC | one subtract-and-shift step per cycle, WIDTH steps total
//   S_DONE | sign fix-up and result publish; may accept a new start
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_dvd_orig;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dbz_pend;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_quo_res;
    logic [WIDTH-1:0] w_rem_res;
    logic             w_accept;

    // Operand magnitudes, the restoring step and the final sign fix-up.
    always_comb begin
        w_dvd_neg = is_signed & dividend[WIDTH-1];
        w_dvs_neg = is_signed & divisor[WIDTH-1];
        w_dvd_mag = w_dvd_neg ? (~dividend + ONE) : dividend;
        w_dvs_mag = w_dvs_neg ? (~divisor + ONE) : divisor;

        // One extra bit keeps a 2^(WIDTH-1) magnitude exact and gives the
        // trial result a clean sign bit.
        w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
        w_trial   = w_rem_sh - {1'b0, r_dvs};
        w_fits    = ~w_trial[WIDTH];
        w_rem_nxt = w_fits ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};

        // A zero divisor still runs the full loop; the architectural result
        // is forced here rather than derived from the loop output.
        if (r_dbz_pend) begin
            w_quo_res = '1;
            w_rem_res = r_dvd_orig;
        end else begin
            w_quo_res = r_q_neg ? (~r_quo + ONE) : r_quo;
            w_rem_res = r_r_neg ? (~r_rem + ONE) : r_rem;
        end

        w_accept = start & (r_state != S_CALC);
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_dvd_orig  <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_dbz_pend  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - CNT_LAST;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_done      <= 1'b1;
                    r_quotient  <= w_quo_res;
                    r_remainder <= w_rem_res;
                    r_dbz       <= r_dbz_pend;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Accepted from IDLE or DONE; in DONE the result above is built
            // from the old registers, so the new load does not disturb it.
            if (w_accept) begin
                r_quo      <= w_dvd_mag;
                r_dvs      <= w_dvs_mag;
                r_rem      <= '0;
                r_dvd_orig <= dividend;
                r_q_neg    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                r_r_neg    <= w_dvd_neg;
                r_dbz_pend <= (divisor == '0);
                r_cnt      <= CNT_INIT;
                r_busy     <= 1'b1;
                r_state    <= S_CALC;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
